// File: rtl/mgc_axi_slave_pkg.sv
// Shared types and the burst address stepping function for mgc_axi_slave_mem.
// MGC_AXI_SLAVE_RD_WAIT_EN adds the R_WAIT read state.
package mgc_axi_slave_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

`ifdef MGC_AXI_SLAVE_RD_WAIT_EN
    typedef enum logic [1:0] {
        R_IDLE,
        R_DATA,
        R_WAIT
    } rd_state_e;
`else
    typedef enum logic [0:0] {
        R_IDLE,
        R_DATA
    } rd_state_e;
`endif

    // Byte address of the beat after addr. Reserved bursts step like INCR.
    // An illegal WRAP length gives a meaningless address; the caller flags it.
    function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                              input logic [2:0]  size,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [63:0] step;
        logic [63:0] span;
        logic [63:0] nxt;
        step = 64'd1 << size;
        span = (64'(len) + 64'd1) << size;
        nxt  = addr + step;
        case (burst)
            FIXED:   return addr;
            WRAP:    return (addr & ~(span - 64'd1)) | (nxt & (span - 64'd1));
            default: return nxt;
        endcase
    endfunction

endpackage

// File: rtl/mgc_axi_slave_addr_gen.sv
// Burst address and beat tracker for one AXI direction.
// LOOKAHEAD=1 reports the beat that the registers will hold after this edge,
// so a registered read port can fetch that beat's data in the same cycle.
module mgc_axi_slave_addr_gen
    import mgc_axi_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter bit LOOKAHEAD  = 1'b0
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         i_load,
    input  logic                         i_adv,
    input  logic [ADDR_WIDTH-1:0]        i_addr,
    input  logic [7:0]                   i_len,
    input  logic [2:0]                   i_size,
    input  logic [1:0]                   i_burst,
    output logic [$clog2(MEM_DEPTH)-1:0] o_word,
    output logic                         o_last,
    output logic                         o_err
);

    localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * (DATA_WIDTH / 8));

    logic [ADDR_WIDTH-1:0] r_addr, w_n_addr, w_v_addr;
    logic [7:0]            r_beat, w_n_beat, w_v_beat;
    logic [7:0]            r_len,  w_n_len,  w_v_len;
    logic [2:0]            r_size, w_n_size, w_v_size;
    logic [1:0]            r_burst, w_n_burst, w_v_burst;
    logic                  w_bad_size, w_bad_wrap, w_bad_type, w_bad_addr;

    // Next-state of the burst tracker: load on address handshake, step on data handshake.
    always_comb begin
        w_n_addr  = r_addr;
        w_n_beat  = r_beat;
        w_n_len   = r_len;
        w_n_size  = r_size;
        w_n_burst = r_burst;
        if (i_load) begin
            w_n_addr  = i_addr;
            w_n_beat  = 8'd0;
            w_n_len   = i_len;
            w_n_size  = i_size;
            w_n_burst = i_burst;
        end else if (i_adv) begin
            w_n_addr = ADDR_WIDTH'(next_addr(64'(r_addr), r_size, r_len, r_burst));
            w_n_beat = r_beat + 8'd1;
        end
    end

    // Burst tracker registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_addr  <= '0;
            r_beat  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else begin
            r_addr  <= w_n_addr;
            r_beat  <= w_n_beat;
            r_len   <= w_n_len;
            r_size  <= w_n_size;
            r_burst <= w_n_burst;
        end
    end

    assign w_v_addr  = LOOKAHEAD ? w_n_addr  : r_addr;
    assign w_v_beat  = LOOKAHEAD ? w_n_beat  : r_beat;
    assign w_v_len   = LOOKAHEAD ? w_n_len   : r_len;
    assign w_v_size  = LOOKAHEAD ? w_n_size  : r_size;
    assign w_v_burst = LOOKAHEAD ? w_n_burst : r_burst;

    assign w_bad_size = w_v_size > 3'(BYTE_SH);
    assign w_bad_wrap = (w_v_burst == WRAP) &&
                        !(w_v_len == 8'd1 || w_v_len == 8'd3 || w_v_len == 8'd7 || w_v_len == 8'd15);
    assign w_bad_type = (w_v_burst == 2'b11);
    assign w_bad_addr = {1'b0, w_v_addr} >= MEM_BYTES;

    assign o_word = IDX_W'(w_v_addr >> BYTE_SH);
    assign o_last = (w_v_beat == w_v_len);
    assign o_err  = w_bad_size | w_bad_wrap | w_bad_type | w_bad_addr;

endmodule

// File: rtl/mgc_axi_slave_mem.sv
// AXI4 slave memory responder: independent write and read FSMs, one
// outstanding transaction per direction, read-before-write on collisions.
// Optional MGC_AXI_SLAVE_RD_WAIT_EN inserts RD_WAIT idle cycles before the first R beat.
module mgc_axi_slave_mem
    import mgc_axi_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256,
    parameter int RD_WAIT    = 2
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    wr_state_e             r_wr_state;
    logic                  r_awready, r_wready, r_bvalid;
    resp_e                 r_bresp;
    logic [ID_WIDTH-1:0]   r_bid;

    rd_state_e             r_rd_state;
    logic                  r_arready, r_rvalid, r_rlast;
    resp_e                 r_rresp;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_aw_hs, w_w_hs, w_w_err, w_mem_we;
    logic                  w_ar_hs, w_r_adv, w_rd_fill;
    logic [IDX_W-1:0]      w_wr_word, w_rd_word;
    logic                  w_wr_last, w_wr_err, w_rd_last, w_rd_err;

`ifdef MGC_AXI_SLAVE_RD_WAIT_EN
    localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    logic [WAIT_W-1:0]     r_wait_cnt;
`endif

    assign w_aw_hs  = r_awready & AWVALID;
    assign w_w_hs   = r_wready & WVALID;
    assign w_w_err  = w_wr_err | (WLAST != w_wr_last);
    assign w_mem_we = w_w_hs & ~w_wr_err;
    assign w_ar_hs  = r_arready & ARVALID;
    assign w_r_adv  = r_rvalid & RREADY & ~r_rlast;

    mgc_axi_slave_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH), .LOOKAHEAD(1'b0)
    ) u_aw_gen (
        .ACLK(ACLK), .ARESET(ARESET), .i_load(w_aw_hs), .i_adv(w_w_hs),
        .i_addr(AWADDR), .i_len(AWLEN), .i_size(AWSIZE), .i_burst(AWBURST),
        .o_word(w_wr_word), .o_last(w_wr_last), .o_err(w_wr_err)
    );

    mgc_axi_slave_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH), .LOOKAHEAD(1'b1)
    ) u_ar_gen (
        .ACLK(ACLK), .ARESET(ARESET), .i_load(w_ar_hs), .i_adv(w_r_adv),
        .i_addr(ARADDR), .i_len(ARLEN), .i_size(ARSIZE), .i_burst(ARBURST),
        .o_word(w_rd_word), .o_last(w_rd_last), .o_err(w_rd_err)
    );

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge ACLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) r_mem[w_wr_word][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    // Write FSM: address, data beats, then held B response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b1;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= OKAY;
            r_bid      <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: if (w_aw_hs) begin
                    r_bid      <= AWID;
                    r_bresp    <= OKAY;
                    r_awready  <= 1'b0;
                    r_wready   <= 1'b1;
                    r_wr_state <= W_DATA;
                end
                W_DATA: if (w_w_hs) begin
                    if (w_w_err) r_bresp <= SLVERR;
                    if (WLAST || w_wr_last) begin
                        r_wready   <= 1'b0;
                        r_bvalid   <= 1'b1;
                        r_wr_state <= W_RESP;
                    end
                end
                W_RESP: if (BREADY) begin
                    r_bvalid   <= 1'b0;
                    r_awready  <= 1'b1;
                    r_wr_state <= W_IDLE;
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    // Marks the edges at which the next R beat is fetched into the output registers.
    always_comb begin
        w_rd_fill = 1'b0;
        case (r_rd_state)
`ifdef MGC_AXI_SLAVE_RD_WAIT_EN
            R_IDLE:  w_rd_fill = w_ar_hs && (RD_WAIT == 0);
            R_WAIT:  w_rd_fill = (r_wait_cnt == '0);
`else
            R_IDLE:  w_rd_fill = w_ar_hs;
`endif
            R_DATA:  w_rd_fill = w_r_adv;
            default: w_rd_fill = 1'b0;
        endcase
    end

    // Read FSM: address handshake, optional wait, then R beats until RLAST is taken.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rid      <= '0;
`ifdef MGC_AXI_SLAVE_RD_WAIT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            case (r_rd_state)
                R_IDLE: if (w_ar_hs) begin
                    r_rid     <= ARID;
                    r_arready <= 1'b0;
`ifdef MGC_AXI_SLAVE_RD_WAIT_EN
                    if (RD_WAIT == 0) begin
                        r_rvalid   <= 1'b1;
                        r_rd_state <= R_DATA;
                    end else begin
                        r_wait_cnt <= WAIT_W'(RD_WAIT - 1);
                        r_rd_state <= R_WAIT;
                    end
`else
                    r_rvalid   <= 1'b1;
                    r_rd_state <= R_DATA;
`endif
                end
`ifdef MGC_AXI_SLAVE_RD_WAIT_EN
                R_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_rvalid   <= 1'b1;
                        r_rd_state <= R_DATA;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end
                end
`endif
                R_DATA: if (RREADY && r_rlast) begin
                    r_rvalid   <= 1'b0;
                    r_arready  <= 1'b1;
                    r_rd_state <= R_IDLE;
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // R beat registers: loaded only on fetch so they hold steady through stalls.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rdata <= '0;
            r_rresp <= OKAY;
            r_rlast <= 1'b0;
        end else if (w_rd_fill) begin
            r_rdata <= w_rd_err ? '0 : r_mem[w_rd_word];
            r_rresp <= w_rd_err ? SLVERR : OKAY;
            r_rlast <= w_rd_last;
        end else if (r_rvalid && RREADY && r_rlast) begin
            r_rlast <= 1'b0;
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign BID     = r_bid;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RLAST   = r_rlast;
    assign RRESP   = r_rresp;
    assign RID     = r_rid;
    assign RDATA   = r_rdata;

endmodule
